// File: rtl/master_out.sv
// Serial-transmit side of a bus master: latches a host request, wins the bus, shifts sel/addr/burst/data MSB first.
// Latency: 1 REQ + 2 SEL + 1 WAIT_SLV + 12 ADDR + 12 BURST + 8*(burst+1) WDATA or RWAIT + 1 DONE cycles after IDLE.
// Backpressure: holds in REQ until granted and not busy, in WAIT_SLV until slave_ready, in RWAIT until rx_done.
module master_out (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  instruction,
  input  logic [1:0]  slave_select,
  input  logic [11:0] address,
  input  logic [7:0]  data,
  input  logic [11:0] burst_num,
  input  logic        approval_grant,
  input  logic        busy,
  input  logic        slave_ready,
  input  logic        rx_done,
  output logic        approval_request,
  output logic        tx_slave_select,
  output logic        master_ready,
  output logic        master_valid,
  output logic        tx_address,
  output logic        tx_burst_number,
  output logic        tx_data,
  output logic        tx_done,
  output logic        write_en,
  output logic        read_en
);

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    SEL,
    WAIT_SLV,
    ADDR,
    BURST,
    WDATA,
    RWAIT,
    DONE
  } state_t;

  // Request fields captured in IDLE; host-side changes afterwards are ignored.
  typedef struct packed {
    logic        is_read;
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [11:0] burst;
  } req_t;

  state_t      state;
  state_t      state_nxt;
  req_t        req_q;
  // One shift register serves every field: each field is loaded left-aligned
  // and the MSB (bit 11) is always the bit on the wire.
  logic [11:0] shreg;
  logic [3:0]  bit_cnt;
  // 13 bits so burst_num = 12'hFFF (4096 beats) never wraps.
  logic [12:0] beat_cnt;
  // Low for the first cycle after a reset edge so master_ready rises only
  // on the first edge after reset is released.
  logic        live;

  logic        sel_last;
  logic        field_last;
  logic        byte_last;
  logic        beat_last;
  logic        shifting;
  logic        beat_start;

  assign sel_last   = (bit_cnt == 4'd1);
  assign field_last = (bit_cnt == 4'd11);
  assign byte_last  = (bit_cnt == 4'd7);
  assign beat_last  = (beat_cnt == {1'b0, req_q.burst});
  assign shifting   = (state == SEL) || (state == ADDR) ||
                      (state == BURST) || (state == WDATA);
  // A data beat starts either when leaving BURST for a write or when the
  // previous beat ends and more beats remain.
  assign beat_start = ((state == BURST) && (state_nxt == WDATA)) ||
                      ((state == WDATA) && byte_last && !beat_last);

  // Next-state decision; each wait state samples only its own handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (live && instruction[1]) state_nxt = REQ;
      REQ:      if (approval_grant && !busy) state_nxt = SEL;
      SEL:      if (sel_last) state_nxt = WAIT_SLV;
      WAIT_SLV: if (slave_ready) state_nxt = ADDR;
      ADDR:     if (field_last) state_nxt = BURST;
      BURST:    if (field_last) state_nxt = req_q.is_read ? RWAIT : WDATA;
      WDATA:    if (byte_last && beat_last) state_nxt = DONE;
      RWAIT:    if (rx_done) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register and the reset-release flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // Capture the host request when a transaction is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q <= '0;
    end else if ((state == IDLE) && (state_nxt == REQ)) begin
      req_q.is_read <= instruction[0];
      req_q.sel     <= slave_select;
      req_q.addr    <= address;
      req_q.burst   <= burst_num;
    end
  end

  // Bit counter: restarts on every state change and at each data-beat boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt <= '0;
    end else if ((state_nxt != state) || beat_start) begin
      bit_cnt <= '0;
    end else if (shifting) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Beat counter: cleared on entry to WDATA, advanced at each new beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if ((state == BURST) && (state_nxt == WDATA)) begin
      beat_cnt <= '0;
    end else if (beat_start) begin
      beat_cnt <= beat_cnt + 13'd1;
    end
  end

  // Load each field left-aligned on entry to its shift state, else shift left.
  // Write data is sampled here, at the edge that opens each beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
    end else if ((state == REQ) && (state_nxt == SEL)) begin
      shreg <= {req_q.sel, 10'd0};
    end else if ((state == WAIT_SLV) && (state_nxt == ADDR)) begin
      shreg <= req_q.addr;
    end else if ((state == ADDR) && (state_nxt == BURST)) begin
      shreg <= req_q.burst;
    end else if (beat_start) begin
      shreg <= {data, 4'd0};
    end else if (shifting) begin
      shreg <= {shreg[10:0], 1'b0};
    end
  end

  // Outputs decoded from the current state; serial lines are gated so they
  // read 0 outside their own shift state.
  always_comb begin
    approval_request = 1'b0;
    tx_slave_select  = 1'b0;
    master_ready     = 1'b0;
    master_valid     = 1'b0;
    tx_address       = 1'b0;
    tx_burst_number  = 1'b0;
    tx_data          = 1'b0;
    tx_done          = 1'b0;
    write_en         = 1'b0;
    read_en          = 1'b0;
    case (state)
      IDLE: begin
        master_ready = live;
      end
      REQ, WAIT_SLV: begin
        approval_request = 1'b1;
      end
      SEL: begin
        approval_request = 1'b1;
        master_valid     = 1'b1;
        tx_slave_select  = shreg[11];
      end
      ADDR: begin
        approval_request = 1'b1;
        master_valid     = 1'b1;
        tx_address       = shreg[11];
      end
      BURST: begin
        approval_request = 1'b1;
        master_valid     = 1'b1;
        tx_burst_number  = shreg[11];
      end
      WDATA: begin
        approval_request = 1'b1;
        master_valid     = 1'b1;
        tx_data          = shreg[11];
        write_en         = 1'b1;
      end
      RWAIT: begin
        approval_request = 1'b1;
        read_en          = 1'b1;
      end
      DONE: begin
        tx_done = 1'b1;
      end
      default: begin
        master_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_master_out.sv
// Directed bench for master_out: write, read, burst write, held-instruction restart, reset abort, no-op, 4096-beat burst.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every comparison is an immediate assertion; failures are counted and reported.
module tb_master_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  instruction;
  logic [1:0]  slave_select;
  logic [11:0] address;
  logic [7:0]  data;
  logic [11:0] burst_num;
  logic        approval_grant;
  logic        busy;
  logic        slave_ready;
  logic        rx_done;
  logic        approval_request;
  logic        tx_slave_select;
  logic        master_ready;
  logic        master_valid;
  logic        tx_address;
  logic        tx_burst_number;
  logic        tx_data;
  logic        tx_done;
  logic        write_en;
  logic        read_en;

  int n_chk  = 0;
  int n_fail = 0;

  // Output snapshot order:
  // {approval_request, master_ready, master_valid, tx_slave_select,
  //  tx_address, tx_burst_number, tx_data, tx_done, write_en, read_en}
  localparam logic [9:0] O_ZERO  = 10'b00_0000_0000;
  localparam logic [9:0] O_IDLE  = 10'b01_0000_0000;
  localparam logic [9:0] O_REQ   = 10'b10_0000_0000;
  localparam logic [9:0] O_RWAIT = 10'b10_0000_0001;
  localparam logic [9:0] O_DONE  = 10'b00_0000_0100;

  master_out dut (
    .clk              (clk),
    .reset            (reset),
    .instruction      (instruction),
    .slave_select     (slave_select),
    .address          (address),
    .data             (data),
    .burst_num        (burst_num),
    .approval_grant   (approval_grant),
    .busy             (busy),
    .slave_ready      (slave_ready),
    .rx_done          (rx_done),
    .approval_request (approval_request),
    .tx_slave_select  (tx_slave_select),
    .master_ready     (master_ready),
    .master_valid     (master_valid),
    .tx_address       (tx_address),
    .tx_burst_number  (tx_burst_number),
    .tx_data          (tx_data),
    .tx_done          (tx_done),
    .write_en         (write_en),
    .read_en          (read_en)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {approval_request, master_ready, master_valid, tx_slave_select,
            tx_address, tx_burst_number, tx_data, tx_done, write_en, read_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect n serial bits from one line (0 sel, 1 addr, 2 burst, 3 data),
  // checking the value, the valid count and that other lines stay quiet.
  task automatic shift_field(input string tag, input int n, input int line,
                             input logic [31:0] exp);
    logic [31:0] v;
    logic [3:0]  lines;
    logic        other;
    int          vld;
    v = '0;
    other = 1'b0;
    vld = 0;
    for (int i = 0; i < n; i++) begin
      lines = {tx_data, tx_burst_number, tx_address, tx_slave_select};
      v = {v[30:0], lines[line]};
      other = other | ((lines & ~(4'b0001 << line)) != 4'b0000);
      vld += int'(master_valid);
      tick();
    end
    chk({tag, " bits"}, v, exp);
    chk({tag, " valid"}, vld, n);
    chk({tag, " quiet"}, {31'd0, other}, 32'd0);
  endtask

  initial begin
    logic [7:0]  beat_v [3];
    logic [7:0]  next_d [3];
    logic [7:0]  v8;
    int          we_cnt;
    int          cyc;
    logic        seen_done;

    reset = 1'b0;
    instruction = 2'b00;
    slave_select = 2'b00;
    address = 12'h000;
    data = 8'h00;
    burst_num = 12'h000;
    approval_grant = 1'b0;
    busy = 1'b0;
    slave_ready = 1'b0;
    rx_done = 1'b0;

    // Reset: everything low, master_ready only after release.
    tick();
    chk("reset outs", outs(), O_ZERO);
    reset = 1'b1;
    tick();
    chk("post-reset idle", outs(), O_IDLE);

    // Single write, grant after 2 REQ cycles, slave_ready after 2 WAIT cycles.
    instruction = 2'b10; slave_select = 2'b10; address = 12'h553;
    burst_num = 12'h000; data = 8'h09;
    tick();
    chk("wr req1", outs(), O_REQ);
    tick();
    chk("wr req2", outs(), O_REQ);
    approval_grant = 1'b1; instruction = 2'b00;
    tick();
    shift_field("wr sel", 2, 0, 32'h2);
    chk("wr wait1", outs(), O_REQ);
    tick();
    chk("wr wait2", outs(), O_REQ);
    slave_ready = 1'b1;
    tick();
    slave_ready = 1'b0;
    shift_field("wr addr", 12, 1, 32'h553);
    shift_field("wr burst", 12, 2, 32'h000);
    v8 = '0; we_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      v8 = {v8[6:0], tx_data};
      we_cnt += int'(write_en);
      if (i == 2) data = 8'hAA;
      tick();
    end
    chk("wr data", v8, 8'h09);
    chk("wr write_en cycles", we_cnt, 8);
    chk("wr done", outs(), O_DONE);
    tick();
    chk("wr back idle", outs(), O_IDLE);

    // Read, busy held for 2 REQ cycles with grant high.
    instruction = 2'b11; slave_select = 2'b11; address = 12'h553;
    burst_num = 12'h003; approval_grant = 1'b1; busy = 1'b1; slave_ready = 1'b1;
    tick();
    chk("rd req1", outs(), O_REQ);
    tick();
    chk("rd req busy1", outs(), O_REQ);
    tick();
    chk("rd req busy2", outs(), O_REQ);
    busy = 1'b0; instruction = 2'b00;
    tick();
    shift_field("rd sel", 2, 0, 32'h3);
    chk("rd wait", outs(), O_REQ);
    tick();
    shift_field("rd addr", 12, 1, 32'h553);
    shift_field("rd burst", 12, 2, 32'h003);
    chk("rd rwait1", outs(), O_RWAIT);
    tick();
    chk("rd rwait2", outs(), O_RWAIT);
    tick();
    chk("rd rwait3", outs(), O_RWAIT);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("rd done", outs(), O_DONE);
    tick();
    chk("rd back idle", outs(), O_IDLE);

    // Three-beat write; data changes mid-beat, grant drops and address changes during ADDR.
    instruction = 2'b10; slave_select = 2'b01; address = 12'h0FF;
    burst_num = 12'h002; data = 8'hA5; approval_grant = 1'b1; slave_ready = 1'b1;
    next_d[0] = 8'h3C; next_d[1] = 8'hC3; next_d[2] = 8'h5A;
    tick();
    chk("bw req", outs(), O_REQ);
    tick();
    shift_field("bw sel", 2, 0, 32'h1);
    tick();
    approval_grant = 1'b0; address = 12'hFFF;
    shift_field("bw addr", 12, 1, 32'h0FF);
    shift_field("bw burst", 12, 2, 32'h002);
    we_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      beat_v[b] = '0;
      for (int i = 0; i < 8; i++) begin
        beat_v[b] = {beat_v[b][6:0], tx_data};
        we_cnt += int'(write_en);
        if (i == 3) data = next_d[b];
        tick();
      end
    end
    chk("bw beat0", beat_v[0], 8'hA5);
    chk("bw beat1", beat_v[1], 8'h3C);
    chk("bw beat2", beat_v[2], 8'hC3);
    chk("bw write_en cycles", we_cnt, 24);
    chk("bw done", outs(), O_DONE);

    // Held instruction: IDLE for one cycle after DONE, then a new REQ.
    tick();
    chk("held idle", outs(), O_IDLE);
    approval_grant = 1'b1;
    tick();
    chk("held restart req", outs(), O_REQ);
    tick();
    tick();
    tick();
    tick();
    chk("restart addr msb", outs(), 10'b10_1010_0000);
    tick();
    tick();

    // Reset mid-ADDR aborts with no tx_done.
    reset = 1'b0; instruction = 2'b00;
    tick();
    chk("abort outs", outs(), O_ZERO);
    reset = 1'b1;
    tick();
    chk("abort idle", outs(), O_IDLE);

    // No-op instructions leave the master idle.
    instruction = 2'b01;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_done = seen_done | tx_done | approval_request;
    end
    chk("noop 01 idle", outs(), O_IDLE);
    instruction = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_done = seen_done | tx_done | approval_request;
    end
    chk("noop 00 idle", outs(), O_IDLE);
    chk("no done/request after abort", {31'd0, seen_done}, 32'd0);

    // Maximum burst: 4096 beats, 32768 write_en cycles, no counter wrap.
    instruction = 2'b10; slave_select = 2'b00; address = 12'h001;
    burst_num = 12'hFFF; data = 8'h81; approval_grant = 1'b1; slave_ready = 1'b1;
    tick();
    instruction = 2'b00;
    we_cnt = 0; cyc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 40000) begin
      we_cnt += int'(write_en);
      seen_done = tx_done;
      if (!seen_done) tick();
      cyc++;
    end
    chk("max burst done seen", {31'd0, seen_done}, 32'd1);
    chk("max burst write_en cycles", we_cnt, 32768);
    tick();
    chk("max burst back idle", outs(), O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
